lfsr_scrambler_pipe: RTL and testbench

Parametrised, registered LFSR engine for the scrambler datapath. Each accepted beat advances a STATE_W-bit Galois LFSR by DATA_W bits. In accumulate mode the beat's data is absorbed into the state (CRC/signature style). In additive mode the beat's data is XORed with the keystream (scramble/descramble). It sits between the framer and the serialiser, replacing fixed-width combinational LFSR slices with a valid/ready pipeline stage that supports seed loading, per-frame reseed and beat counting.

---
 rtl/lfsr_scrambler_pipe.sv | 160 ++++++++++++++++
 tb/tb_lfsr_scrambler_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_scrambler_pipe.sv
// -----------------------------------------------------------------------------
// lfsr_scrambler_pipe
//
// Registered Galois-LFSR engine for the scrambler datapath. Each accepted beat
// advances the STATE_W-bit LFSR by DATA_W single-bit steps within one cycle.
//   mode = 0 (accumulate): beat data is shifted into the state (signature /
//                          CRC style); the data passes through unchanged.
//   mode = 1 (additive)  : state free-runs, and the data is XORed with the
//                          keystream (the MSB seen before each step).
// The result is held in a single output register. The stage supports seed
// loading, automatic reseed at frame end and a saturating beat counter.
//
// Handshake: a beat transfers on a port when valid & ready are both high on a
// rising clock edge. in_ready = !out_valid | out_ready, so the stage streams one
// beat per cycle while downstream keeps out_ready high, and stalls with its
// output frozen while out_valid & !out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   mode       0 = accumulate, 1 = additive; sampled with each accepted beat
//   load       seed load strobe (honoured in any handshake state)
//   load_seed  value written to the state on load
//   in_valid   input beat valid
//   in_ready   stage can accept a beat (combinational)
//   in_data    beat data, bit 0 processed first
//   in_last    final beat of a frame
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   out_data   processed beat data
//   out_state  LFSR state after the beat (pre-reseed on a last beat)
//   out_last   copy of in_last for the beat
//   beat_cnt   beats accepted since reset or the last frame end (saturating)
// -----------------------------------------------------------------------------
module lfsr_scrambler_pipe #(
  parameter int                 STATE_W   = 60,
  parameter int                 DATA_W    = 15,
  parameter logic [STATE_W-1:0] POLY      = 60'h000000418000001,
  parameter logic [STATE_W-1:0] SEED      = '0,
  parameter bit                 AUTO_SEED = 1'b1,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               load,
  input  logic [STATE_W-1:0] load_seed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [STATE_W-1:0] out_state,
  output logic               out_last,
  output logic [CNT_W-1:0]   beat_cnt
);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic accept;   // input beat transfers this cycle
  logic consume;  // output beat leaves this cycle

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // LFSR state register and beat datapath
  // ---------------------------------------------------------------------------
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] beat_start;  // state the beat begins from
  logic [STATE_W-1:0] beat_state;  // state after all DATA_W steps
  logic [DATA_W-1:0]  beat_data;   // processed data for the beat
  logic [STATE_W-1:0] walk;        // state as it moves through the steps
  logic               fb;          // MSB before the current step
  logic               din;         // bit shifted into bit 0 this step

  // A load in the same cycle as an accept takes effect for that beat.
  assign beat_start = load ? load_seed : state_q;

  // Unrolled DATA_W steps; step i sees the state left by step i-1.
  always_comb begin
    walk      = beat_start;
    beat_data = '0;
    fb        = 1'b0;
    din       = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      fb = walk[STATE_W-1];
      if (mode) begin
        // Additive: keystream bit is the MSB before the step; no data feedback.
        beat_data[i] = in_data[i] ^ fb;
        din          = 1'b0;
      end else begin
        // Accumulate: data is absorbed into the state and passed through.
        beat_data[i] = in_data[i];
        din          = in_data[i];
      end
      walk = {walk[STATE_W-2:0], 1'b0} ^ (fb ? POLY : '0)
             ^ {{(STATE_W-1){1'b0}}, din};
    end
    beat_state = walk;
  end

  // The reseed on a last beat only affects the running state; the output
  // register still receives the un-reseeded result as the frame signature.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED;
    end else if (accept) begin
      state_q <= (AUTO_SEED && in_last) ? SEED : beat_state;
    end else if (load) begin
      state_q <= load_seed;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register (single entry, full/empty flag is out_valid)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_state <= SEED;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= beat_data;
      out_state <= beat_state;
      out_last  <= in_last;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat counter
  // The last beat's count stays visible for one cycle (the frame length);
  // the counter restarts on the following cycle, counting a beat accepted
  // in that same cycle as the first of the new frame.
  // ---------------------------------------------------------------------------
  logic cnt_clear_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt    <= '0;
      cnt_clear_q <= 1'b0;
    end else begin
      if (cnt_clear_q) begin
        beat_cnt <= accept ? CNT_W'(1) : '0;
      end else if (accept && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      cnt_clear_q <= accept && in_last;
    end
  end

endmodule

// File: tb/tb_lfsr_scrambler_pipe.sv
// -----------------------------------------------------------------------------
// tb_lfsr_scrambler_pipe
//
// Main instance uses the default 60/15 configuration; a second instance with
// DATA_W=1 covers the single-bit vectors. Expected beats come from polynomial
// arithmetic over GF(2): a beat is (s * x^N + data) mod P, and the keystream
// bit for step i is the top coefficient of (s * x^i) mod P.
// -----------------------------------------------------------------------------
module tb_lfsr_scrambler_pipe;

  localparam int          SW   = 60;
  localparam int          DW   = 15;
  localparam int          CW   = 16;
  localparam int          EW   = DW + SW + 1;
  localparam logic [59:0] POLY = 60'h000000418000001;
  localparam logic [59:0] SEED = 60'h0;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic          mode, load, in_valid, in_ready, in_last;
  logic          out_valid, out_ready, out_last;
  logic [SW-1:0] load_seed, out_state;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] beat_cnt;

  // DATA_W=1 instance signals
  logic          mode_b, load_b, in_valid_b, in_ready_b, in_last_b;
  logic          out_valid_b, out_ready_b, out_last_b;
  logic [SW-1:0] load_seed_b, out_state_b;
  logic [0:0]    in_data_b, out_data_b;
  logic [CW-1:0] beat_cnt_b;

  lfsr_scrambler_pipe #(
    .STATE_W(SW), .DATA_W(DW), .POLY(POLY), .SEED(SEED), .AUTO_SEED(1'b1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .load(load), .load_seed(load_seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_state(out_state), .out_last(out_last), .beat_cnt(beat_cnt)
  );

  lfsr_scrambler_pipe #(
    .STATE_W(SW), .DATA_W(1), .POLY(POLY), .SEED(SEED), .AUTO_SEED(1'b1), .CNT_W(CW)
  ) dut1 (
    .clk(clk), .rst(rst), .mode(mode_b), .load(load_b), .load_seed(load_seed_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_last(in_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_state(out_state_b), .out_last(out_last_b), .beat_cnt(beat_cnt_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and model state
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;
  int hs_err  = 0;   // cycles where in_ready/out_valid disagreed with the model

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  logic [SW-1:0] m_state;
  logic [CW-1:0] m_cnt;
  bit            m_clear;
  bit            m_full;

  function automatic logic [SW-1:0] poly_mod(input logic [127:0] v_in);
    logic [127:0] v;
    logic [127:0] pf;
    v  = v_in;
    pf = {67'b0, 1'b1, POLY};
    for (int b = 127; b >= SW; b--) begin
      if (v[b]) v = v ^ (pf << (b - SW));
    end
    return v[SW-1:0];
  endfunction

  task automatic model_beat(input logic [SW-1:0] s0, input logic [DW-1:0] d, input bit m,
                            output logic [SW-1:0] s1, output logic [DW-1:0] od);
    logic [127:0] v;
    logic [SW-1:0] t;
    od = d;
    if (!m) begin
      v = {68'b0, s0} << DW;
      for (int i = 0; i < DW; i++) v[DW-1-i] = v[DW-1-i] ^ d[i];
      s1 = poly_mod(v);
    end else begin
      s1 = poly_mod({68'b0, s0} << DW);
      for (int i = 0; i < DW; i++) begin
        t     = poly_mod({68'b0, s0} << i);
        od[i] = d[i] ^ t[SW-1];
      end
    end
  endtask

  task automatic model_reset();
    m_state = SEED;
    m_cnt   = '0;
    m_clear = 1'b0;
    m_full  = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called at a negedge, drives one cycle, returns at the next negedge
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input bit m, input bit l,
                             input bit ld, input logic [SW-1:0] sd, input bit ordy);
    logic [SW-1:0] s0, s1;
    logic [DW-1:0] od;
    bit            acc, exp_ready;
    in_valid = v; in_data = d; mode = m; in_last = l;
    load = ld; load_seed = sd; out_ready = ordy;
    #1;
    exp_ready = !m_full || ordy;
    if (in_ready !== exp_ready || out_valid !== m_full) hs_err++;
    if (m_full && ordy) obs_q.push_back({out_data, out_state, out_last});
    acc = v && exp_ready;
    if (acc) begin
      s0 = ld ? sd : m_state;
      model_beat(s0, d, m, s1, od);
      exp_q.push_back({od, s1, l});
      m_state = l ? SEED : s1;
    end else if (ld) begin
      m_state = sd;
    end
    if (m_clear) m_cnt = acc ? CW'(1) : '0;
    else if (acc && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    m_clear = acc && l;
    if (acc) m_full = 1'b1;
    else if (m_full && ordy) m_full = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && m_full; k++) drive_cycle(0, '0, 0, 0, 0, '0, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
    n_total++; if (out_state !== SEED) $display("FAIL reset_out_state: got %h want %h", out_state, SEED); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else n_pass++;
    n_total++; if (beat_cnt !== '0) $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid_b !== 1'b0) $display("FAIL reset_out_valid_b: got %b want 0", out_valid_b); else n_pass++;
  endtask

  task automatic test_single_bit();
    logic [SW-1:0] top_seed;
    top_seed = {1'b1, 59'b0};
    // accumulate, data 0: x^60 mod P = POLY
    load_b = 1; load_seed_b = top_seed; in_valid_b = 1; mode_b = 0; in_data_b = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid_b !== 1'b1) $display("FAIL bit1_acc_valid: got %b want 1", out_valid_b); else n_pass++;
    n_total++; if (out_state_b !== POLY) $display("FAIL bit1_acc_state: got %h want %h", out_state_b, POLY); else n_pass++;
    n_total++; if (out_data_b !== 1'b0) $display("FAIL bit1_acc_data: got %b want 0", out_data_b); else n_pass++;
    // additive, data 0: keystream bit is the seed MSB
    mode_b = 1;
    @(negedge clk);
    n_total++; if (out_data_b !== 1'b1) $display("FAIL bit1_add_data: got %b want 1", out_data_b); else n_pass++;
    n_total++; if (out_state_b !== POLY) $display("FAIL bit1_add_state: got %h want %h", out_state_b, POLY); else n_pass++;
    load_b = 0; in_valid_b = 0; mode_b = 0;
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    logic [EW-1:0] e, o;
    drive_cycle(1, '0, 0, 0, 1, 60'h1, 1);
    n_total++; if (out_state !== 60'h8000) $display("FAIL vec_acc_state: got %h want 8000", out_state); else n_pass++;
    drive_cycle(1, '0, 1, 0, 1, 60'h1, 1);
    n_total++; if (out_data !== '0) $display("FAIL vec_add_data: got %h want 0", out_data); else n_pass++;
    drive_cycle(1, 15'h5a3c, 1, 0, 1, {1'b1, 59'h0123456789abcde}, 1);
    drive_cycle(1, 15'h7fff, 0, 0, 0, '0, 1);
    drain();
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL vec_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL vec_beat: got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] first, e, o;
    drive_cycle(0, '0, 0, 0, 1, 60'($urandom()) << 28 ^ 60'($urandom()), 1);
    drive_cycle(1, 15'($urandom()), 1'($urandom()), 0, 0, '0, 0);
    first = exp_q[exp_q.size()-1];
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1, 15'($urandom()), 1'($urandom()), 0, 0, '0, 0);
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
      n_total++;
      if ({out_data, out_state, out_last} !== first)
        $display("FAIL bp_hold: got %h want %h", {out_data, out_state, out_last}, first);
      else n_pass++;
    end
    for (int k = 0; k < 6; k++) drive_cycle(1, 15'($urandom()), 1'($urandom()), 0, 0, '0, 1);
    drain();
    n_total++; if (obs_q.size() != 7 || exp_q.size() != 7) $display("FAIL bp_count: got %0d want 7 (expected %0d)", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL bp_beat: got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_total++; if (hs_err != 0) $display("FAIL bp_handshake: got %0d errors want 0", hs_err); else n_pass++;
    hs_err = 0;
  endtask

  task automatic test_frame();
    logic [EW-1:0] e, o, sig;
    logic [SW-1:0] s1;
    logic [DW-1:0] od, d5;
    // close whatever frame earlier beats belonged to
    drive_cycle(1, 15'($urandom()), 0, 1, 0, '0, 1);
    drive_cycle(0, '0, 0, 0, 1, 60'($urandom()) << 30 ^ 60'($urandom()), 1);
    n_total++; if (beat_cnt !== '0) $display("FAIL frame_cnt_start: got %0d want 0", beat_cnt); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      drive_cycle(1, 15'($urandom()), 1'($urandom()), k == 4, 0, '0, 1);
      n_total++; if (beat_cnt !== CW'(k)) $display("FAIL frame_cnt: got %0d want %0d", beat_cnt, k); else n_pass++;
    end
    sig = exp_q[exp_q.size()-1];
    n_total++; if (out_state !== sig[SW:1]) $display("FAIL frame_signature: got %h want %h", out_state, sig[SW:1]); else n_pass++;
    n_total++; if (out_last !== 1'b1) $display("FAIL frame_out_last: got %b want 1", out_last); else n_pass++;
    drive_cycle(0, '0, 0, 0, 0, '0, 1);
    n_total++; if (beat_cnt !== '0) $display("FAIL frame_cnt_clear: got %0d want 0", beat_cnt); else n_pass++;
    // next beat starts from SEED
    d5 = 15'($urandom()) | 15'h1;
    drive_cycle(1, d5, 0, 0, 0, '0, 1);
    model_beat(SEED, d5, 0, s1, od);
    n_total++; if (out_state !== s1) $display("FAIL frame_reseed: got %h want %h", out_state, s1); else n_pass++;
    n_total++; if (beat_cnt !== CW'(1)) $display("FAIL frame_cnt_next: got %0d want 1", beat_cnt); else n_pass++;
    drain();
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL frame_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL frame_beat: got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_load_accept();
    logic [EW-1:0] e, o, held;
    logic [SW-1:0] seed_b;
    logic [SW-1:0] s1;
    logic [DW-1:0] od, d;
    drive_cycle(0, '0, 0, 0, 1, 60'h0f0f_0f0f_0f0f_0f0, 1);
    seed_b = 60'($urandom()) << 29 ^ 60'($urandom());
    d = 15'($urandom());
    drive_cycle(1, d, 0, 0, 1, seed_b, 1);
    model_beat(seed_b, d, 0, s1, od);
    n_total++; if (out_state !== s1) $display("FAIL load_accept_state: got %h want %h", out_state, s1); else n_pass++;
    // stall the output, then load: held beat must not change
    drive_cycle(1, 15'($urandom()), 1, 0, 0, '0, 0);
    held = exp_q[exp_q.size()-1];
    drive_cycle(0, '0, 0, 0, 1, 60'($urandom()) << 27 ^ 60'($urandom()), 0);
    n_total++;
    if ({out_data, out_state, out_last} !== held)
      $display("FAIL load_hold: got %h want %h", {out_data, out_state, out_last}, held);
    else n_pass++;
    drive_cycle(1, 15'($urandom()), 1'($urandom()), 0, 0, '0, 1);
    drain();
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL load_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL load_beat: got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random_stream();
    logic [EW-1:0] e, o;
    for (int k = 0; k < 80; k++) begin
      drive_cycle($urandom_range(0, 3) != 0, 15'($urandom()), 1'($urandom()),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  60'($urandom()) << 30 ^ 60'($urandom()), $urandom_range(0, 9) < 7);
    end
    drain();
    n_total++; if (beat_cnt !== m_cnt) $display("FAIL rand_beat_cnt: got %0d want %0d", beat_cnt, m_cnt); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL rand_beat: got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_total++; if (hs_err != 0) $display("FAIL rand_handshake: got %0d errors want 0", hs_err); else n_pass++;
    hs_err = 0;
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] s1;
    logic [DW-1:0] od, d;
    drive_cycle(0, '0, 0, 0, 1, 60'h123_4567_89ab_cdef, 1);
    drive_cycle(1, 15'($urandom()), 0, 0, 0, '0, 1);
    drive_cycle(1, 15'($urandom()), 1, 0, 0, '0, 0);
    #2 rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (beat_cnt !== '0) $display("FAIL rstmid_beat_cnt: got %0d want 0", beat_cnt); else n_pass++;
    n_total++; if (out_state !== SEED) $display("FAIL rstmid_out_state: got %h want %h", out_state, SEED); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    d = 15'($urandom()) | 15'h4000;
    drive_cycle(1, d, 0, 0, 0, '0, 1);
    model_beat(SEED, d, 0, s1, od);
    n_total++; if (out_state !== s1) $display("FAIL rstmid_seed_state: got %h want %h", out_state, s1); else n_pass++;
    n_total++; if (out_data !== d) $display("FAIL rstmid_data: got %h want %h", out_data, d); else n_pass++;
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    mode = 0; load = 0; load_seed = '0; in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
    mode_b = 0; load_b = 0; load_seed_b = '0; in_valid_b = 0; in_data_b = '0; in_last_b = 0; out_ready_b = 1;
    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    test_single_bit();
    test_known_vectors();
    test_backpressure();
    test_frame();
    test_load_accept();
    test_random_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
